// File: rtl/fd_pkg.sv
// fd_pkg: shared types and constants for the frame_drawer write FIFO.
package fd_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} fdw_state_t;
  localparam logic SRAM_RD = 1'b1;
  localparam logic SRAM_WR = 1'b0;
  localparam int FD_ADDR_W = 20;
  localparam int FD_DATA_W = 16;
  typedef struct packed {
    logic [FD_ADDR_W-1:0] addr;
    logic [FD_DATA_W-1:0] data;
  } fd_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count and first-word fall-through head.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 36,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/fd_write_fifo.sv
// fd_write_fifo: buffers frame_drawer pixel writes and drains them to sram_ctrl during VGA blanking.
module fd_write_fifo
  import fd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  input  logic                   blank_n,
  input  logic [ADDR_W-1:0]      pixel_addr,
  input  logic                   sram_ready,
  output logic                   sram_start_n,
  output logic                   sram_rw,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   late_write
);
  fdw_state_t state_q, state_d;
  logic full, push, pop;
  logic [ADDR_W+DATA_W-1:0] head;
  assign wr_ready = !full;
  assign push = wr_valid && wr_ready;
  assign pop = state_q == WAIT_DONE && sram_ready;
  sync_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .din({wr_addr, wr_data}),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!empty && !blank_n && sram_ready) state_d = ISSUE;
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: if (!sram_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (sram_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Head only advances at WAIT_DONE exit, so address/data hold for the whole write.
  assign sram_rw = state_q == IDLE ? SRAM_RD : SRAM_WR;
  assign sram_start_n = state_q != ISSUE;
  assign sram_addr = sram_rw == SRAM_WR ? head[ADDR_W+DATA_W-1:DATA_W] : pixel_addr;
  assign sram_wdata = head[DATA_W-1:0];
  assign late_write = pop && blank_n;
endmodule

// File: tb/tb_fd_write_fifo.sv
// tb_fd_write_fifo: directed self-checking bench for fd_write_fifo with a small sram_ctrl handshake model.
module tb_fd_write_fifo;
  logic clk = 0, reset_n = 0, wr_valid = 0, blank_n = 0, sram_ready;
  logic [19:0] wr_addr = '0, pixel_addr = 20'h12345, sram_addr;
  logic [15:0] wr_data = '0, sram_wdata;
  logic wr_ready, sram_start_n, sram_rw, empty, late_write;
  logic [4:0] count;
  int n_checks = 0, n_fail = 0;
  int lat_cnt, start_cnt = 0, late_cnt = 0, track_err = 0;
  int s0, l0, ls0;
  logic [35:0] log_q[$];

  fd_write_fifo dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .blank_n(blank_n),
    .pixel_addr(pixel_addr), .sram_ready(sram_ready), .sram_start_n(sram_start_n),
    .sram_rw(sram_rw), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .count(count), .empty(empty), .late_write(late_write)
  );

  always #5 clk = ~clk;

  // sram_ctrl model: ready drops for two cycles after each start pulse
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_ready <= 1'b1;
      lat_cnt <= 0;
    end else if (!sram_start_n) begin
      sram_ready <= 1'b0;
      lat_cnt <= 2;
    end else if (!sram_ready) begin
      if (lat_cnt == 1) sram_ready <= 1'b1;
      lat_cnt <= lat_cnt - 1;
    end
  end

  always @(posedge clk) if (reset_n && !sram_start_n) log_q.push_back({sram_addr, sram_wdata});

  always @(negedge clk) begin
    #2;
    if (!sram_start_n) start_cnt++;
    if (late_write) late_cnt++;
    if (sram_rw && sram_addr !== pixel_addr) track_err++;
  end

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [19:0] a, input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    wr_valid = 1; wr_addr = a; wr_data = d;
    while (!wr_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t == 300) check("push_timeout", wr_ready, 1);
    @(posedge clk);
    #1 wr_valid = 0;
  endtask

  task automatic wait_drain(input int n, input int budget);
    int t = 0;
    while ((log_q.size() < n || count != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t == budget) check("drain_timeout", count, 0);
  endtask

  task automatic wait_issue();
    int t = 0;
    while (sram_start_n && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("issue_timeout", sram_start_n, 0);
  endtask

  initial begin
    // reset values
    reset_n = 0; wr_valid = 1; blank_n = 0;
    repeat (3) @(negedge clk);
    check("rst_start_n", sram_start_n, 1);
    check("rst_rw", sram_rw, 1);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_addr", sram_addr, 20'h12345);
    check("rst_late", late_write, 0);
    wr_valid = 0;
    @(negedge clk) reset_n = 1;

    // single push during blanking
    s0 = start_cnt;
    push(20'h0012C, 16'h0003);
    @(negedge clk);
    check("t2_idle_start_n", sram_start_n, 1);
    check("t2_count1", count, 1);
    @(negedge clk);
    check("t2_issue_start_n", sram_start_n, 0);
    check("t2_issue_rw", sram_rw, 0);
    check("t2_issue_addr", sram_addr, 20'h0012C);
    check("t2_issue_wdata", sram_wdata, 16'h0003);
    @(negedge clk);
    check("t2_busy_start_n", sram_start_n, 1);
    check("t2_busy_rw", sram_rw, 0);
    @(negedge clk);
    check("t2_done_addr", sram_addr, 20'h0012C);
    check("t2_done_wdata", sram_wdata, 16'h0003);
    check("t2_done_count", count, 1);
    @(negedge clk);
    check("t2_done_rw", sram_rw, 0);
    @(negedge clk);
    check("t2_count0", count, 0);
    check("t2_empty", empty, 1);
    check("t2_rw_rd", sram_rw, 1);
    check("t2_addr_pix", sram_addr, 20'h12345);
    check("t2_starts", start_cnt - s0, 1);
    check("t2_log_n", log_q.size(), 1);
    check("t2_log0", log_q[0], {20'h0012C, 16'h0003});

    // pushes during active display, drained after blank_n falls
    log_q.delete();
    blank_n = 1;
    pixel_addr = 20'h00777;
    s0 = start_cnt;
    push(20'h00001, 16'h00A1);
    push(20'h00002, 16'h00A2);
    push(20'h00003, 16'h00A3);
    repeat (5) @(negedge clk);
    check("t3_count3", count, 3);
    check("t3_no_start", start_cnt - s0, 0);
    check("t3_addr_pix", sram_addr, 20'h00777);
    blank_n = 0;
    wait_drain(3, 100);
    check("t3_log_n", log_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t3_log%0d", i), log_q[i], {20'(i + 1), 16'(16'hA1 + i)});

    // full FIFO: 17th entry waits for the first completed write
    log_q.delete();
    blank_n = 1;
    for (int i = 0; i < 16; i++) push(20'h00100 + 20'(i), 16'h0200 + 16'(i));
    @(negedge clk);
    check("t4_count16", count, 16);
    check("t4_full_ready", wr_ready, 0);
    wr_valid = 1; wr_addr = 20'h00110; wr_data = 16'h0210;
    repeat (3) @(negedge clk);
    check("t4_hold_count", count, 16);
    check("t4_hold_ready", wr_ready, 0);
    blank_n = 0;
    push(20'h00110, 16'h0210);
    @(negedge clk);
    check("t4_accept_log", log_q.size(), 1);
    check("t4_accept_count", count, 16);
    wait_drain(17, 200);
    check("t4_log_n", log_q.size(), 17);
    for (int i = 0; i < 17; i++)
      if (i < log_q.size())
        check($sformatf("t4_log%0d", i), log_q[i], {20'h00100 + 20'(i), 16'h0200 + 16'(i)});

    // blank_n rises while waiting for sram busy
    log_q.delete();
    blank_n = 1;
    push(20'h00300, 16'h0055);
    push(20'h00301, 16'h0066);
    @(negedge clk) blank_n = 0;
    wait_issue();
    @(negedge clk) blank_n = 1;
    check("t5_busy_rw", sram_rw, 0);
    #3;
    s0 = start_cnt;
    l0 = late_cnt;
    repeat (20) @(negedge clk);
    check("t5_late_once", late_cnt - l0, 1);
    check("t5_no_start", start_cnt - s0, 0);
    check("t5_count1", count, 1);
    check("t5_log_n", log_q.size(), 1);
    check("t5_log0", log_q[0], {20'h00300, 16'h0055});

    // reset during WAIT_DONE with five entries buffered
    push(20'h00400, 16'h0001);
    push(20'h00401, 16'h0002);
    push(20'h00402, 16'h0003);
    push(20'h00403, 16'h0004);
    @(negedge clk);
    check("t6_count5", count, 5);
    blank_n = 0;
    wait_issue();
    @(negedge clk);
    @(negedge clk);
    check("t6_done_rw", sram_rw, 0);
    reset_n = 0;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_start_n", sram_start_n, 1);
    check("t6_rst_rw", sram_rw, 1);
    check("t6_rst_ready", wr_ready, 1);
    s0 = start_cnt;
    ls0 = log_q.size();
    @(negedge clk) reset_n = 1;
    repeat (20) @(negedge clk);
    check("t6_no_start", start_cnt - s0, 0);
    check("t6_no_write", log_q.size(), ls0);
    check("t6_count0", count, 0);

    check("addr_tracks_pixel", track_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fd_write_fifo.md
Name: fd_write_fifo

Overview:
- Buffers (address, colour) pixel writes from frame_drawer and drains them to sram_ctrl only while the VGA is blanking.
- Sits between frame_drawer (upstream) and sram_ctrl (downstream).
- Owns the SRAM read/write direction and the address mux. VGA pixel reads get the bus during active display; buffered writes get it during blanking.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, minimum 2.
- ADDR_W, 20: SRAM word address width.
- DATA_W, 16: pixel word (colour enum) width.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  frame_drawer has a pixel write pending.
- wr_addr  in  ADDR_W  write address from frame_drawer.
- wr_data  in  DATA_W  colour word from frame_drawer.
- wr_ready  out  1  FIFO can accept a push this cycle (not full).
- blank_n  in  1  VGA_BLANK_N; 0 = blanking, so writes are allowed.
- pixel_addr  in  ADDR_W  VGA read address (DrawY*640+DrawX).
- sram_ready  in  1  sram_ctrl idle/done flag.
- sram_start_n  out  1  one-cycle active-low start pulse to sram_ctrl.
- sram_rw  out  1  1 = read, 0 = write; drives sram_ctrl rw.
- sram_addr  out  ADDR_W  head address when sram_rw=0, else pixel_addr.
- sram_wdata  out  DATA_W  head data word.
- count  out  $clog2(DEPTH)+1  current occupancy.
- empty  out  1  count==0.
- late_write  out  1  one-cycle pulse when a write completes after blank_n has risen.

Behaviour:
- Reset (async, reset_n=0) values:
  - pointers and count = 0, empty=1, wr_ready=1;
  - state = IDLE, sram_start_n=1, sram_rw=1, late_write=0;
  - sram_addr follows pixel_addr.
- Push:
  - An entry is accepted on a rising edge when wr_valid & wr_ready.
  - wr_ready = (count != DEPTH), combinational from registered count.
  - The writer holds wr_valid, wr_addr and wr_data until accepted. Nothing is ever dropped.
- Pop:
  - The head advances only on completion of an SRAM write, on exit from WAIT_DONE.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM (registered state; outputs are Moore-decoded from state):
  - IDLE: sram_rw=1. Go to ISSUE when !empty & !blank_n & sram_ready.
  - ISSUE: sram_rw=0, sram_start_n=0, for exactly one cycle. Then go to WAIT_BUSY.
  - WAIT_BUSY: sram_rw=0. Go to WAIT_DONE when sram_ready==0.
  - WAIT_DONE: sram_rw=0. When sram_ready==1: pop, go to IDLE, and pulse late_write if blank_n==1 in that cycle.
- Latency:
  - A push accepted at edge E0 into an empty FIFO, with blanking active and sram_ready=1, gives FSM=ISSUE after E1.
  - sram_start_n is therefore low during cycle E1..E2.
  - Minimum 4 cycles per drained entry. IDLE may re-enter ISSUE on the cycle after a pop.
- sram_addr and sram_wdata:
  - sram_wdata is the head entry and is stable from ISSUE through WAIT_DONE, because pop occurs only at exit.
  - sram_addr is a combinational mux on sram_rw.
- blank_n rising mid-transaction:
  - An in-flight write (ISSUE, WAIT_BUSY or WAIT_DONE) always runs to completion.
  - No new ISSUE is started while blank_n=1.
- Full FIFO: wr_ready=0 until the first pop completes. The push is then accepted on the following edge.
- Reset mid-transaction: all state is cleared immediately and buffered entries are discarded. sram_ctrl is reset by the same reset_n.
- Ordering: strict FIFO, so SRAM write order equals push order.

Decomposition:
- Package fd_pkg:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} fdw_state_t;
  - constants SRAM_RD=1'b1 and SRAM_WR=1'b0;
  - typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} fd_entry_t.
- One sub-module: sync_fifo (storage, pointers, count, full/empty), instantiated once. The drain FSM stays in fd_write_fifo.

Test Plan:
- Reset values:
  - Stimulus: reset_n=0 with wr_valid=1, blank_n=0.
  - Response: sram_start_n=1, sram_rw=1, count=0, empty=1, wr_ready=1, sram_addr==pixel_addr.
- Single push during blanking:
  - Stimulus: blank_n=0; push addr=0x0012C, data=0x0003; SRAM model drops ready for 2 cycles.
  - Response: one sram_start_n low pulse 1 cycle after the push edge; sram_rw=0 with sram_addr=0x0012C, sram_wdata=0x0003 until ready returns; then count=0.
- Push during active display:
  - Stimulus: blank_n=1; push 3 entries.
  - Response: count=3, no start pulse while blank_n=1.
  - Follow-on: blank_n falls; writes 0x00001, 0x00002, 0x00003 issue in push order; sram_addr tracks pixel_addr whenever sram_rw=1.
- Full FIFO:
  - Stimulus: blank_n=1; wr_valid held with 17 distinct entries.
  - Response: wr_ready=0 after the 16th; the 17th stays unaccepted.
  - Follow-on: blank_n falls; after the first write completes, the 17th is accepted; all 17 are written in order with no loss.
- blank_n rises in WAIT_BUSY:
  - Response: the write completes and late_write pulses once; no further start pulse; count decrements by exactly 1.
- Reset mid-transaction:
  - Stimulus: reset_n=0 in WAIT_DONE with 5 entries.
  - Response: immediate IDLE, count=0, sram_start_n=1, sram_rw=1; no writes after release until new pushes.
